// File: rtl/alarm_mode_ctrl.sv
// alarm_mode_ctrl: mode/adjust controller for the multi-alarm clock.
// States ADJ, CLOCK, RING, SNOOZE. Triggers are qualified by tick_1s at
// second 0, so returning to CLOCK inside second 0 cannot re-fire.
// Optional feature macro: ALARM_SNOOZE_EN (snooze state and counter).
// Without it, any button in RING dismisses to CLOCK.
// Button pulses are single-cycle and carry no handshake: a pulse is consumed
// in the cycle it is seen, and only the highest-priority one acts
// (center > right > left > up > down).
module alarm_mode_ctrl #(
  parameter int NUM_ALARMS     = 2,
  parameter int SNOOZE_S       = 300,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    up,
  input  logic                    down,
  input  logic                    left,
  input  logic                    right,
  input  logic                    center,
  input  logic                    tick_1s,
  input  logic [5:0]              secs,
  input  logic [NUM_ALARMS-1:0]   match,
  output logic [2*NUM_ALARMS+1:0] EN,
  output logic                    run,
  output logic                    adjust,
  output logic                    inc,
  output logic                    dec,
  output logic                    led,
  output logic [2:0]              ring_id,
  output logic [1:0]              state_dbg
);

  localparam int NF = 2*NUM_ALARMS + 2;
  localparam int FW = $clog2(NF);
  localparam int TW = $clog2(RING_TIMEOUT_S + 1);

  typedef enum logic [1:0] {
    ADJ    = 2'd0,
    CLOCK  = 2'd1,
    RING   = 2'd2,
    SNOOZE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   fld_q, fld_d;
  logic [2:0]      id_d;
  logic [TW-1:0]   t_cnt;
  logic            load_t;
  logic            b_center, b_right, b_left, b_up, b_down, any_btn;
  logic            trigger;
  logic [2:0]      first_id;

`ifdef ALARM_SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_S + 1);
  logic [SW-1:0]   s_cnt;
  logic            load_s;
`endif

  // Button priority resolution, trigger qualification and lowest-index match.
  always_comb begin
    b_center = center;
    b_right  = !center && right;
    b_left   = !center && !right && left;
    b_up     = !center && !right && !left && up;
    b_down   = !center && !right && !left && !up && down;
    any_btn  = center | right | left | up | down;
    trigger  = tick_1s && (secs == 6'd0) && (|match);
    first_id = 3'd0;
    for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
      if (match[k]) first_id = 3'(k);
    end
  end

  // Next-state, field pointer and ring index selection.
  always_comb begin
    state_d = state_q;
    fld_d   = fld_q;
    id_d    = ring_id;
    load_t  = 1'b0;
`ifdef ALARM_SNOOZE_EN
    load_s  = 1'b0;
`endif
    case (state_q)
      ADJ: begin
        if (b_center) begin
          state_d = CLOCK;
        end else if (b_right) begin
          fld_d = (fld_q == FW'(NF - 1)) ? '0 : fld_q + 1'b1;
        end else if (b_left) begin
          fld_d = (fld_q == '0) ? FW'(NF - 1) : fld_q - 1'b1;
        end
      end
      CLOCK: begin
        if (trigger) begin
          state_d = RING;
          id_d    = first_id;
          load_t  = 1'b1;
        end else if (b_center) begin
          state_d = ADJ;
          fld_d   = '0;
        end
      end
      RING: begin
`ifdef ALARM_SNOOZE_EN
        if (b_center) begin
          state_d = CLOCK;
        end else if (any_btn) begin
          state_d = SNOOZE;
          load_s  = 1'b1;
        end else if (t_cnt == '0) begin
          state_d = CLOCK;
        end
`else
        if (any_btn || (t_cnt == '0)) state_d = CLOCK;
`endif
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (b_center) begin
          state_d = CLOCK;
        end else if (trigger) begin
          state_d = RING;
          id_d    = first_id;
          load_t  = 1'b1;
        end else if (s_cnt == '0) begin
          state_d = RING;
          load_t  = 1'b1;
        end
      end
`endif
      default: state_d = ADJ;
    endcase
  end

  // Moore outputs decoded from state and field pointer.
  always_comb begin
    EN        = (state_q == ADJ) ? ({{(NF-1){1'b0}}, 1'b1} << fld_q) : '0;
    run       = (state_q != ADJ);
    adjust    = ~run;
    led       = (state_q == RING);
    state_dbg = state_q;
  end

  // State, field pointer, ring index and registered edit strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ADJ;
      fld_q   <= '0;
      ring_id <= 3'd0;
      inc     <= 1'b0;
      dec     <= 1'b0;
    end else begin
      state_q <= state_d;
      fld_q   <= fld_d;
      ring_id <= id_d;
      inc     <= (state_q == ADJ) && b_up;
      dec     <= (state_q == ADJ) && b_down;
    end
  end

  // Ring timeout: loads on RING entry, counts ticks down, holds at zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      t_cnt <= '0;
    end else if (load_t) begin
      t_cnt <= TW'(RING_TIMEOUT_S);
    end else if ((state_q == RING) && tick_1s && (t_cnt != '0)) begin
      t_cnt <= t_cnt - 1'b1;
    end
  end

`ifdef ALARM_SNOOZE_EN
  // Snooze timer: loads on SNOOZE entry, counts ticks down, holds at zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_cnt <= '0;
    end else if (load_s) begin
      s_cnt <= SW'(SNOOZE_S);
    end else if ((state_q == SNOOZE) && tick_1s && (s_cnt != '0)) begin
      s_cnt <= s_cnt - 1'b1;
    end
  end
`endif

endmodule
